// File: rtl/reset_pulse_gen_pkg.sv
// reset_pulse_gen_pkg: shared state encoding, counter width and helpers for reset_pulse_gen.
package reset_pulse_gen_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus history flop; flags a rising edge of the async level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/reset_pulse_gen.sv
// reset_pulse_gen: fixed-width registered reset pulses from an async level or sync strobe,
// each followed by a hold-off window that drops (and flags) any retrigger.
module reset_pulse_gen
    import reset_pulse_gen_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_async,
    input  logic       sw_req,
    output logic       rst_out,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [7:0] pulse_count
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       count_q, count_d;
    logic             rst_out_q, busy_q, done_q, done_d, overrun_q, overrun_d;
    logic             async_edge, req, accept;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (req_async),
        .edge_o  (async_edge)
    );

    assign req = async_edge | sw_req;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: accept = req;
            ASSERT: begin
                overrun_d = req;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = HOLDOFF;
                    cnt_d   = HOLD_LOAD;
                    done_d  = 1'b1;
                end
            end
            HOLDOFF: begin
                // the final hold-off cycle already counts as idle, so a request here is taken
                if (cnt_q != '0) begin
                    cnt_d     = cnt_q - 1'b1;
                    overrun_d = req;
                end else begin
                    accept  = req;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            state_d = ASSERT;
            cnt_d   = PULSE_LOAD;
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            count_q   <= '0;
            rst_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            rst_out_q <= (state_d == ASSERT);
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign rst_out     = rst_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign pulse_count = count_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// tb_reset_pulse_gen: scenario tasks checked against a time-since-pulse-start reference model.
module tb_reset_pulse_gen;

    localparam int P   = 4;
    localparam int H   = 2;
    localparam int BIG = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_async = 1'b0;
    logic       sw_req = 1'b0;
    logic       rst_out, busy, done, overrun;
    logic [7:0] pulse_count;

    int         checks = 0;
    int         errors = 0;

    int         since = BIG;
    logic [7:0] m_count = '0;
    bit         m_over = 1'b0;
    bit         p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;

    reset_pulse_gen #(.PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_async   (req_async),
        .sw_req      (sw_req),
        .rst_out     (rst_out),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .pulse_count (pulse_count)
    );

    always #5 clk = ~clk;

    wire [11:0] dut_vec = {rst_out, busy, done, overrun, pulse_count};

    function automatic logic [11:0] exp_vec();
        return {since < P, since < P + H, since == P, m_over, m_count};
    endfunction

    // The model counts cycles since the last accepted pulse began; async edges come from sampled history.
    task automatic tick(input bit r, input bit a, input bit s);
        bit e;
        rst = r;
        req_async = a;
        sw_req = s;
        @(posedge clk);
        if (r) begin
            since = BIG;
            m_count = '0;
            m_over = 1'b0;
            p1 = 1'b0;
            p2 = 1'b0;
            p3 = 1'b0;
        end else begin
            e = p2 & ~p3;
            p3 = p2;
            p2 = p1;
            p1 = a;
            if (since < BIG) since++;
            m_over = 1'b0;
            if (e | s) begin
                if (since >= P + H) begin
                    since = 0;
                    if (m_count != 8'd255) m_count++;
                end else begin
                    m_over = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0);
        tick(1, 0, 0);
        checks++;
        if (dut_vec !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, 12'h000);
        end
        tick(0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_sw_pulse();
        for (int k = 0; k < 3; k++) tick(0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, k == 0);
            checks++;
            if (rst_out !== (k < P) || done !== (k == P) || busy !== (k < P + H) || pulse_count !== 8'd1) begin
                errors++;
                $display("FAIL sw_pulse k=%0d got rst_out=%b done=%b busy=%b cnt=%0d exp %b %b %b 1",
                         k, rst_out, done, busy, pulse_count, k < P, k == P, k < P + H);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sw_pulse_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async();
        logic [7:0] base = m_count;
        int         highs = 0;
        for (int j = 0; j < 14; j++) begin
            tick(0, j < 10, 0);
            highs += int'(rst_out);
            checks++;
            if (rst_out !== (j >= 2 && j <= 5)) begin
                errors++;
                $display("FAIL async_latency j=%0d got=%b exp=%b", j, rst_out, j >= 2 && j <= 5);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL async_model j=%0d got=%h exp=%h", j, dut_vec, exp_vec());
            end
        end
        checks++;
        if (pulse_count !== base + 8'd1 || highs != P) begin
            errors++;
            $display("FAIL async_single got cnt=%0d highs=%0d exp cnt=%0d highs=%0d", pulse_count, highs, base + 8'd1, P);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] base = m_count;
        for (int k = 0; k < 12; k++) begin
            tick(0, 0, k == 0 || k == 2 || k == 5 || k == 6);
            checks++;
            if (overrun !== (k == 2 || k == 5) || pulse_count !== base + ((k < 6) ? 8'd1 : 8'd2)) begin
                errors++;
                $display("FAIL overrun k=%0d got ovr=%b cnt=%0d exp ovr=%b cnt=%0d", k, overrun, pulse_count,
                         k == 2 || k == 5, base + ((k < 6) ? 8'd1 : 8'd2));
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL overrun_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 11; k++) begin
            tick(k == 2, 0, k == 0);
            if (k == 2) begin
                checks++;
                if (rst_out !== 1'b0 || busy !== 1'b0 || pulse_count !== 8'd0) begin
                    errors++;
                    $display("FAIL mid_reset got rst_out=%b busy=%b cnt=%0d exp 0 0 0", rst_out, busy, pulse_count);
                end
            end
            if (k >= 2) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_done k=%0d got=%b exp=0", k, done);
                end
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL mid_reset_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_coincide();
        logic [7:0] base = m_count;
        for (int j = 0; j < 12; j++) begin
            tick(0, j < 6, j == 2);
            checks++;
            if (rst_out !== (j >= 2 && j <= 5) || overrun !== 1'b0) begin
                errors++;
                $display("FAIL coincide j=%0d got rst_out=%b ovr=%b exp %b 0", j, rst_out, overrun, j >= 2 && j <= 5);
            end
        end
        checks++;
        if (pulse_count !== base + 8'd1) begin
            errors++;
            $display("FAIL coincide_count got=%0d exp=%0d", pulse_count, base + 8'd1);
        end
    endtask

    task automatic test_saturate();
        tick(1, 0, 0);
        for (int i = 0; i < 260; i++) begin
            for (int t = 0; t < P + H; t++) begin
                tick(0, 0, t == 0);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL saturate i=%0d t=%0d got=%h exp=%h", i, t, dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (pulse_count !== 8'd255) begin
            errors++;
            $display("FAIL saturate_final got=%0d exp=255", pulse_count);
        end
    endtask

    task automatic test_random();
        bit a = 1'b0;
        tick(1, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) a = ~a;
            tick($urandom_range(199) == 0, a, $urandom_range(7) == 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_pulse();
        test_async();
        test_overrun();
        test_mid_reset();
        test_coincide();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_pulse_gen.md
# reset_pulse_gen

Generates clean, fixed-width, active-high reset pulses for the downstream synchronous/asynchronous-reset flop stage. Its `rst_out` output drives that stage's `rst` input. Pulses can be requested two ways: from an asynchronous external level (`req_async`, e.g. a push-button or test-harness line) or from a synchronous one-cycle strobe (`sw_req`). Each pulse is followed by a hold-off window that blocks retriggering, so the downstream stage always sees well-formed, non-overlapping reset pulses.

## Interface
- `PULSE_CYCLES`, default 4: width of `rst_out` pulse in clock cycles; legal range 1..255.
- `HOLDOFF_CYCLES`, default 2: dead time after each pulse; legal range 1..255.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset for this block.
- `req_async` input 1: asynchronous request level; a rising edge requests one pulse.
- `sw_req` input 1: synchronous request strobe; high in any cycle requests one pulse.
- `rst_out` output 1: registered reset pulse to the downstream stage.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle strobe marking the end of a pulse.
- `overrun` output 1: one-cycle strobe when a request is dropped.
- `pulse_count` output 8: number of pulses issued; saturates at 255.

## Operation
- States:
  - IDLE: waiting for a request.
  - ASSERT: `rst_out` = 1.
  - HOLDOFF: `rst_out` = 0, `busy` = 1.
- The request path for `req_async` is a 2-flop synchronizer (s1, s2) plus a history flop s3. `edge = s2 & ~s3`.
- `req = edge | sw_req`.
- IDLE with `req`:
  - Next state is ASSERT.
  - `cnt` loads `PULSE_CYCLES-1`.
  - `pulse_count` increments, saturating at 255.
- ASSERT:
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, go to HOLDOFF, load `cnt = HOLDOFF_CYCLES-1`, and register `done = 1` for that single cycle.
- HOLDOFF:
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, go to IDLE.
- `rst_out`, `busy`, `done` and `overrun` are all registered; there are no combinational outputs.
- A `req` arriving in ASSERT or HOLDOFF is dropped. It is not queued, `overrun` = 1 for one cycle, and `pulse_count` is unchanged.
- `edge` and `sw_req` in the same IDLE cycle produce exactly one pulse and increment `pulse_count` by 1.
- Reset (`rst` = 1 at an edge) forces all of the following:
  - state = IDLE
  - `cnt` = 0, s1 = s2 = s3 = 0
  - `rst_out` = `busy` = `done` = `overrun` = 0
  - `pulse_count` = 0
- Reset mid-pulse aborts the pulse. `rst_out` is 0 after the reset edge and no `done` is produced.
- A `req_async` level held high through reset is seen as a new edge after release and produces exactly one pulse. This is intended behaviour.
- `rst` has priority over every other input.

## Timing
- `sw_req` sampled high at edge N while in IDLE:
  - `rst_out` = 1 from edge N through edge N+`PULSE_CYCLES`-1.
  - `rst_out` = 0 and `done` = 1 after edge N+`PULSE_CYCLES`.
  - Back in IDLE after edge N+`PULSE_CYCLES`+`HOLDOFF_CYCLES`.
  - The earliest next accepted `sw_req` is sampled at that edge.
- `req_async` first sampled high at edge N: s1 = 1 after N, s2 = 1 after N+1, `edge` is true in the following cycle, and `rst_out` = 1 after edge N+2. That is 2 cycles more latency than `sw_req`.
- `req_async` must stay high for at least 2 clock periods to be guaranteed capture.
- `busy` is high exactly `PULSE_CYCLES`+`HOLDOFF_CYCLES` cycles per pulse.
- `overrun` is registered on the edge at which the dropped `req` is sampled.

## Structure
- The shared package `reset_pulse_gen_pkg` holds:
  - `state_t` enum: IDLE = 2'd0, ASSERT = 2'd1, HOLDOFF = 2'd2.
  - `CNT_W` = 8.
- One sub-module, `sync_edge_detect`: the 2-flop synchronizer plus history flop, with synchronous active-high reset, output `edge`.
- The top level holds the FSM, the shared down-counter `cnt` and the saturating `pulse_count`.
- Illegal state encoding (2'd3) recovers to IDLE on the next edge.

## Test plan
All scenarios use the default parameters (`PULSE_CYCLES` = 4, `HOLDOFF_CYCLES` = 2).
- `sw_req` for 1 cycle at edge 10:
  - `rst_out` = 1 after edges 10–13 and 0 after edge 14.
  - `done` = 1 only after edge 14.
  - `busy` = 0 after edge 16.
  - `pulse_count` = 1.
- `req_async` rises between edges 20 and 21 and is held high for 10 cycles:
  - `rst_out` = 1 after edges 23–26.
  - Exactly one pulse; `pulse_count` increments by 1.
- `sw_req` at edge 10, then again at edges 12 and 15:
  - Both later requests are dropped, `overrun` = 1 after edges 12 and 15, and `pulse_count` = 1.
  - `sw_req` at edge 16 is accepted.
- `rst` asserted at edge 12 during a pulse started at edge 10:
  - After edge 12, `rst_out` = 0, `busy` = 0 and `pulse_count` = 0.
  - No `done` strobe.
- `sw_req` and a synchronized `edge` coincide in IDLE: one pulse; `pulse_count` increments by exactly 1.
- 260 back-to-back accepted requests (one every 6 cycles): `pulse_count` saturates at 255 and `rst_out` pulses continue normally.
